// File: rtl/line_buffer_3x3.sv
// Streaming 3x3 window generator: two line buffers plus column history, emitting
// zero-padded (pad=1) windows at stride 2. Optional o_frame_done port via LB_FRAME_DONE_EN.
module line_buffer_3x3 #(
    parameter int F = 28,
    parameter int B = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [B-1:0]   i_pixel,
    input  logic           i_pixel_valid,
    output logic [9*B-1:0] o_window,
    output logic           o_window_valid
`ifdef LB_FRAME_DONE_EN
    ,
    output logic           o_frame_done
`endif
);

    localparam int            CW   = $clog2(F);
    localparam logic [CW-1:0] LAST = CW'(F - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    // lb1 holds row r-1, lb2 holds row r-2, both indexed by column
    logic [B-1:0] lb1_mem [F];
    logic [B-1:0] lb2_mem [F];

    logic [CW-1:0]  col_q, col_d;
    logic [CW-1:0]  row_q, row_d;
    logic [B-1:0]   hist_q [3][2];
    logic [B-1:0]   hist_d [3][2];
    logic [B-1:0]   new_col [3];
    logic [9*B-1:0] window_q, window_d;
    logic           window_valid_q, window_valid_d;
    logic           emit;
`ifdef LB_FRAME_DONE_EN
    logic           frame_done_q, frame_done_d;
`endif

    always_comb begin
        logic [B-1:0] elem;
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        col_d          = col_q;
        row_d          = row_q;
        hist_d         = hist_q;
        window_d       = window_q;
        window_valid_d = 1'b0;
        elem           = '0;

        // Incoming column, top to bottom: rows r-2, r-1, r
        new_col[0] = lb2_mem[col_q];
        new_col[1] = lb1_mem[col_q];
        new_col[2] = i_pixel;

        emit = i_pixel_valid && row_q[0] && col_q[0];

        if (i_pixel_valid) begin
            col_d = (col_q == LAST) ? '0 : col_q + ONE;
            if (col_q == LAST) begin
                row_d = (row_q == LAST) ? '0 : row_q + ONE;
            end
            for (int r = 0; r < 3; r++) begin
                hist_d[r][0] = hist_q[r][1];
                hist_d[r][1] = new_col[r];
            end
        end

        // Top padding hides stale line-buffer rows; left padding hides the previous row's tail
        if (emit) begin
            window_valid_d = 1'b1;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    elem = (c == 2) ? new_col[r] : hist_q[r][c];
                    if ((r == 0 && row_q == ONE) || (c == 0 && col_q == ONE)) begin
                        elem = '0;
                    end
                    window_d[(r*3+c)*B +: B] = elem;
                end
            end
        end
`ifdef LB_FRAME_DONE_EN
        frame_done_d = emit && (row_q == LAST) && (col_q == LAST);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q          <= '0;
            row_q          <= '0;
            window_q       <= '0;
            window_valid_q <= 1'b0;
`ifdef LB_FRAME_DONE_EN
            frame_done_q   <= 1'b0;
`endif
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            window_q       <= window_d;
            window_valid_q <= window_valid_d;
`ifdef LB_FRAME_DONE_EN
            frame_done_q   <= frame_done_d;
`endif
        end
    end

    // NOTE: storage is deliberately left unreset; padding masks anything not written this frame.
    always_ff @(posedge i_clk) begin
        if (i_pixel_valid) begin
            lb2_mem[col_q] <= new_col[1];
            lb1_mem[col_q] <= i_pixel;
            hist_q         <= hist_d;
        end
    end

    assign o_window       = window_q;
    assign o_window_valid = window_valid_q;
`ifdef LB_FRAME_DONE_EN
    assign o_frame_done   = frame_done_q;
`endif

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Scoreboard bench for line_buffer_3x3: expected windows are queued as pixels are
// driven and compared as pulses appear. Define LB_FRAME_DONE_EN to cover o_frame_done.
module tb_line_buffer_3x3;

    localparam int F  = 28;
    localparam int B  = 8;
    localparam int NW = (F / 2) * (F / 2);

    logic           i_clk;
    logic           i_rst;
    logic [B-1:0]   i_pixel;
    logic           i_pixel_valid;
    logic [9*B-1:0] o_window;
    logic           o_window_valid;
`ifdef LB_FRAME_DONE_EN
    logic           o_frame_done;
`endif

    int checks   = 0;
    int failures = 0;

    logic [9*B-1:0] sb_q[$];
    logic [9*B-1:0] seen[$];
    logic [9*B-1:0] ref_seen[$];

    line_buffer_3x3 #(.F(F), .B(B)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pixel       (i_pixel),
        .i_pixel_valid (i_pixel_valid),
        .o_window      (o_window),
        .o_window_valid(o_window_valid)
`ifdef LB_FRAME_DONE_EN
        ,
        .o_frame_done  (o_frame_done)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [B-1:0] pix(input int r, input int c, input int base);
        return B'(r * F + c + base);
    endfunction

    function automatic logic [9*B-1:0] exp_win(input int r, input int c, input int base);
        logic [9*B-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (r - 2 + i >= 0 && c - 2 + j >= 0) begin
                    w[(i*3+j)*B +: B] = pix(r - 2 + i, c - 2 + j, base);
                end
            end
        end
        return w;
    endfunction

    function automatic logic [9*B-1:0] mk(input int k0, input int k1, input int k2,
                                          input int k3, input int k4, input int k5,
                                          input int k6, input int k7, input int k8);
        return {B'(k8), B'(k7), B'(k6), B'(k5), B'(k4), B'(k3), B'(k2), B'(k1), B'(k0)};
    endfunction

    // Drives npix pixels of a frame starting at (0,0); with gaps, valid is held low ~50% of cycles.
    task automatic run_frame(input int base, input bit gaps, input int npix, input string tag);
        int r = 0;
        int c = 0;
        int n = 0;
        bit v;
        bit exp_v;
        bit exp_last;
        logic [9*B-1:0] last_win;
        logic [9*B-1:0] w;
        last_win = o_window;
        while (n < npix) begin
            v        = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            exp_v    = v && (r % 2 == 1) && (c % 2 == 1);
            exp_last = exp_v && (r == F - 1) && (c == F - 1);
            if (exp_v) sb_q.push_back(exp_win(r, c, base));
            i_pixel_valid = v;
            i_pixel       = v ? pix(r, c, base) : B'($urandom);
            @(posedge i_clk);
            #1;
            checks++;
            if (o_window_valid !== exp_v) begin
                failures++;
                $display("FAIL %s valid r=%0d c=%0d got=%b want=%b", tag, r, c, o_window_valid, exp_v);
            end
`ifdef LB_FRAME_DONE_EN
            checks++;
            if (o_frame_done !== exp_last) begin
                failures++;
                $display("FAIL %s frame_done r=%0d c=%0d got=%b want=%b", tag, r, c, o_frame_done, exp_last);
            end
`endif
            if (o_window_valid === 1'b1) begin
                seen.push_back(o_window);
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_window got=%h want=none", tag, o_window);
                end else begin
                    w = sb_q.pop_front();
                    if (o_window !== w) begin
                        failures++;
                        $display("FAIL %s window r=%0d c=%0d got=%h want=%h", tag, r, c, o_window, w);
                    end
                end
                last_win = o_window;
            end else if (!v && n > 0) begin
                checks++;
                if (o_window !== last_win) begin
                    failures++;
                    $display("FAIL %s hold got=%h want=%h", tag, o_window, last_win);
                end
            end
            if (exp_last) begin
                last_win = o_window;
            end
            if (v) begin
                n++;
                if (c == F - 1) begin
                    c = 0;
                    r = (r == F - 1) ? 0 : r + 1;
                end else begin
                    c++;
                end
            end
        end
    endtask

    task automatic check_count(input string tag);
        checks++;
        if (seen.size() != NW || sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s pulse_count got=%0d want=%0d pending=%0d", tag, seen.size(), NW, sb_q.size());
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        i_pixel_valid = 1'b0;
        i_pixel = '0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (o_window_valid !== 1'b0 || o_window !== '0) begin
            failures++;
            $display("FAIL reset_state got valid=%b win=%h want valid=0 win=0", o_window_valid, o_window);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_mid_reset;
        seen.delete();
        run_frame(100, 1'b0, 3 * F + 5, "pre_reset");
        i_pixel_valid = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_window_valid !== 1'b0 || o_window !== '0) begin
            failures++;
            $display("FAIL mid_reset got valid=%b win=%h want valid=0 win=0", o_window_valid, o_window);
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        sb_q.delete();
        seen.delete();
        run_frame(7, 1'b0, F * F, "after_reset");
        check_count("after_reset");
        i_pixel_valid = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_stream;
        seen.delete();
        run_frame(0, 1'b0, F * F, "stream");
        check_count("stream");
        checks++;
        if (seen.size() < 16 || seen[0] !== mk(0, 0, 0, 0, 0, 1, 0, 28, 29)) begin
            failures++;
            $display("FAIL first_window got=%h want=%h", seen.size() > 0 ? seen[0] : '0,
                     mk(0, 0, 0, 0, 0, 1, 0, 28, 29));
        end
        checks++;
        if (seen.size() < 16 || seen[1] !== mk(0, 0, 0, 1, 2, 3, 29, 30, 31)) begin
            failures++;
            $display("FAIL window_1_3 got=%h want=%h", seen.size() > 1 ? seen[1] : '0,
                     mk(0, 0, 0, 1, 2, 3, 29, 30, 31));
        end
        checks++;
        if (seen.size() < 16 || seen[15] !== mk(29, 30, 31, 57, 58, 59, 85, 86, 87)) begin
            failures++;
            $display("FAIL window_3_3 got=%h want=%h", seen.size() > 15 ? seen[15] : '0,
                     mk(29, 30, 31, 57, 58, 59, 85, 86, 87));
        end
        ref_seen = seen;
        i_pixel_valid = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_gaps;
        int diff = 0;
        seen.delete();
        run_frame(0, 1'b1, F * F, "gaps");
        check_count("gaps");
        foreach (ref_seen[i]) begin
            if (i >= seen.size() || seen[i] !== ref_seen[i]) diff++;
        end
        checks++;
        if (diff != 0 || ref_seen.size() != NW) begin
            failures++;
            $display("FAIL gaps_sequence got=%0d differing want=0 (ref=%0d)", diff, ref_seen.size());
        end
        i_pixel_valid = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_back_to_back;
        seen.delete();
        run_frame(0, 1'b0, F * F, "b2b_f1");
        check_count("b2b_f1");
        seen.delete();
        run_frame(1, 1'b0, F * F, "b2b_f2");
        check_count("b2b_f2");
        checks++;
        if (seen.size() == 0 || seen[0] !== mk(0, 0, 0, 0, 1, 2, 0, 29, 30)) begin
            failures++;
            $display("FAIL b2b_first_window got=%h want=%h", seen.size() > 0 ? seen[0] : '0,
                     mk(0, 0, 0, 0, 1, 2, 0, 29, 30));
        end
        i_pixel_valid = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1;
        i_pixel_valid = 1'b0;
        i_pixel = '0;
        test_reset();
        test_stream();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
